vend_credit_ctrl: RTL and testbench

Parametrised, clocked vending-machine credit controller. It accumulates coin credit in a register with a configurable width and ceiling, and charges a configurable price for each of two items. It sequences a vend handshake, then dispenses change one unit at a time. It sits between the coin-acceptor and selection-button front end and the dispenser and change-hopper drivers, replacing the earlier purely combinational next-credit logic with a registered FSM.

---
 rtl/vend_credit_ctrl.sv | 161 ++++++++++++++++
 tb/tb_vend_credit_ctrl.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/vend_credit_ctrl.sv
// Vending credit controller: accumulates coin credit, sequences a vend handshake, then returns change one unit at a time.
// Latency: one cycle from any accepted strobe to its registered outputs; vend and change steps each take at least one cycle.
// Backpressure: holds vend_req/change_req until vend_ack/change_ack; while busy, coins are rejected and selections/cancels are dropped.
module vend_credit_ctrl #(
    parameter int CREDIT_W    = 4,
    parameter int MAX_CREDIT  = 15,
    parameter int COIN0_VAL   = 1,
    parameter int COIN1_VAL   = 2,
    parameter int COIN2_VAL   = 5,
    parameter int PRICE_A     = 3,
    parameter int PRICE_B     = 4,
    parameter int AUTO_CHANGE = 1
) (
    input  logic                clk,
    input  logic                resetn,
    input  logic                coin_valid,
    input  logic [1:0]          coin_type,
    input  logic                sel_valid,
    input  logic                sel,
    input  logic                cancel,
    input  logic                vend_ack,
    input  logic                change_ack,
    output logic [CREDIT_W-1:0] credit,
    output logic                vend_req,
    output logic                vend_item,
    output logic                change_req,
    output logic                busy,
    output logic                coin_reject,
    output logic                sel_denied
);

    typedef enum logic [1:0] {
        ST_COLLECT = 2'd0,
        ST_VEND    = 2'd1,
        ST_CHANGE  = 2'd2
    } state_t;

    // Ceiling and coin values carried one bit wider so a sum can never wrap.
    localparam logic [CREDIT_W:0]   MAX_W  = (CREDIT_W+1)'(MAX_CREDIT);
    localparam logic [CREDIT_W:0]   COIN0_W = (CREDIT_W+1)'(COIN0_VAL);
    localparam logic [CREDIT_W:0]   COIN1_W = (CREDIT_W+1)'(COIN1_VAL);
    localparam logic [CREDIT_W:0]   COIN2_W = (CREDIT_W+1)'(COIN2_VAL);
    localparam logic [CREDIT_W-1:0] PRICE_A_W = CREDIT_W'(PRICE_A);
    localparam logic [CREDIT_W-1:0] PRICE_B_W = CREDIT_W'(PRICE_B);
    localparam logic [CREDIT_W-1:0] ONE_W     = CREDIT_W'(1);

    state_t              state_q, state_d;
    logic [CREDIT_W-1:0] credit_q, credit_d;
    logic                vend_req_q, vend_req_d;
    logic                vend_item_q, vend_item_d;
    logic                change_req_q, change_req_d;
    logic                busy_q, busy_d;
    logic                coin_reject_q, coin_reject_d;
    logic                sel_denied_q, sel_denied_d;

    logic [CREDIT_W:0]   coin_val;
    logic [CREDIT_W:0]   coin_sum;
    logic [CREDIT_W-1:0] price;

    // Coin value lookup, widened sum and selected price.
    always_comb begin
        coin_val = '0;
        case (coin_type)
            2'b00:   coin_val = COIN0_W;
            2'b01:   coin_val = COIN1_W;
            2'b10:   coin_val = COIN2_W;
            default: coin_val = '0;
        endcase
        coin_sum = {1'b0, credit_q} + coin_val;
        price    = sel ? PRICE_B_W : PRICE_A_W;
    end

    // Next-state logic: cancel beats select beats coin while collecting; busy states only react to their ack.
    always_comb begin
        state_d       = state_q;
        credit_d      = credit_q;
        vend_item_d   = vend_item_q;
        coin_reject_d = 1'b0;
        sel_denied_d  = 1'b0;
        case (state_q)
            ST_COLLECT: begin
                if (cancel) begin
                    coin_reject_d = coin_valid;
                    if (credit_q != '0) begin
                        state_d = ST_CHANGE;
                    end
                end else if (sel_valid) begin
                    coin_reject_d = coin_valid;
                    if (credit_q >= price) begin
                        credit_d    = credit_q - price;
                        vend_item_d = sel;
                        state_d     = ST_VEND;
                    end else begin
                        sel_denied_d = 1'b1;
                    end
                end else if (coin_valid) begin
                    if (coin_type == 2'b11 || coin_sum > MAX_W) begin
                        coin_reject_d = 1'b1;
                    end else begin
                        credit_d = coin_sum[CREDIT_W-1:0];
                    end
                end
            end
            ST_VEND: begin
                coin_reject_d = coin_valid;
                if (vend_ack) begin
                    state_d = (AUTO_CHANGE != 0 && credit_q != '0) ? ST_CHANGE : ST_COLLECT;
                end
            end
            ST_CHANGE: begin
                coin_reject_d = coin_valid;
                if (credit_q == '0) begin
                    state_d = ST_COLLECT;
                end else if (change_ack) begin
                    credit_d = credit_q - ONE_W;
                    if (credit_q == ONE_W) begin
                        state_d = ST_COLLECT;
                    end
                end
            end
            default: begin
                state_d = ST_COLLECT;
            end
        endcase
        vend_req_d   = (state_d == ST_VEND);
        change_req_d = (state_d == ST_CHANGE);
        busy_d       = (state_d != ST_COLLECT);
    end

    // State and registered outputs, synchronous active-low reset drops everything including credit.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q       <= ST_COLLECT;
            credit_q      <= '0;
            vend_req_q    <= 1'b0;
            vend_item_q   <= 1'b0;
            change_req_q  <= 1'b0;
            busy_q        <= 1'b0;
            coin_reject_q <= 1'b0;
            sel_denied_q  <= 1'b0;
        end else begin
            state_q       <= state_d;
            credit_q      <= credit_d;
            vend_req_q    <= vend_req_d;
            vend_item_q   <= vend_item_d;
            change_req_q  <= change_req_d;
            busy_q        <= busy_d;
            coin_reject_q <= coin_reject_d;
            sel_denied_q  <= sel_denied_d;
        end
    end

    assign credit      = credit_q;
    assign vend_req    = vend_req_q;
    assign vend_item   = vend_item_q;
    assign change_req  = change_req_q;
    assign busy        = busy_q;
    assign coin_reject = coin_reject_q;
    assign sel_denied  = sel_denied_q;

endmodule

// File: tb/tb_vend_credit_ctrl.sv
// Directed bench for vend_credit_ctrl with default parameters.
// Inputs change 1 time unit after each rising edge; outputs are checked at that same point.
// Each comparison is an immediate assertion that counts and reports its own miscompare.
module tb_vend_credit_ctrl;

    logic       clk;
    logic       resetn;
    logic       coin_valid;
    logic [1:0] coin_type;
    logic       sel_valid;
    logic       sel;
    logic       cancel;
    logic       vend_ack;
    logic       change_ack;
    logic [3:0] credit;
    logic       vend_req;
    logic       vend_item;
    logic       change_req;
    logic       busy;
    logic       coin_reject;
    logic       sel_denied;

    int vectors;
    int miscompares;

    vend_credit_ctrl dut (
        .clk         (clk),
        .resetn      (resetn),
        .coin_valid  (coin_valid),
        .coin_type   (coin_type),
        .sel_valid   (sel_valid),
        .sel         (sel),
        .cancel      (cancel),
        .vend_ack    (vend_ack),
        .change_ack  (change_ack),
        .credit      (credit),
        .vend_req    (vend_req),
        .vend_item   (vend_item),
        .change_req  (change_req),
        .busy        (busy),
        .coin_reject (coin_reject),
        .sel_denied  (sel_denied)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input int obs, input int exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Advance one edge, then return all one-cycle strobes to idle.
    task automatic tick();
        @(posedge clk);
        #1;
        coin_valid = 1'b0;
        sel_valid  = 1'b0;
        cancel     = 1'b0;
        vend_ack   = 1'b0;
    endtask

    task automatic coin(input logic [1:0] t);
        coin_valid = 1'b1;
        coin_type  = t;
        tick();
    endtask

    task automatic select(input logic s);
        sel_valid = 1'b1;
        sel       = s;
        tick();
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        resetn      = 1'b0;
        coin_valid  = 1'b0;
        coin_type   = 2'b00;
        sel_valid   = 1'b0;
        sel         = 1'b0;
        cancel      = 1'b0;
        vend_ack    = 1'b0;
        change_ack  = 1'b0;
        tick();
        tick();
        chk("rst_credit", credit, 0);
        chk("rst_vend_req", vend_req, 0);
        chk("rst_vend_item", vend_item, 0);
        chk("rst_change_req", change_req, 0);
        chk("rst_busy", busy, 0);
        chk("rst_coin_reject", coin_reject, 0);
        chk("rst_sel_denied", sel_denied, 0);
        resetn = 1'b1;

        // Coin accumulation
        coin(2'b00); chk("c00_credit", credit, 1); chk("c00_rej", coin_reject, 0);
        coin(2'b01); chk("c01a_credit", credit, 3);
        coin(2'b01); chk("c01b_credit", credit, 5); chk("c01b_rej", coin_reject, 0);

        // Ceiling: reach 13, then 15, then overflow and invalid type
        coin(2'b10); chk("c10_credit", credit, 10);
        coin(2'b01); chk("to12_credit", credit, 12);
        coin(2'b00); chk("to13_credit", credit, 13);
        coin(2'b01); chk("to15_credit", credit, 15); chk("to15_rej", coin_reject, 0);
        coin(2'b00); chk("ovf_rej", coin_reject, 1); chk("ovf_credit", credit, 15);
        tick();      chk("ovf_rej_drop", coin_reject, 0);
        coin(2'b11); chk("inv_rej", coin_reject, 1); chk("inv_credit", credit, 15);

        // Cancel at 15, change_ack held; coin during change rejected
        cancel = 1'b1;
        tick();
        chk("cx_change_req", change_req, 1); chk("cx_busy", busy, 1); chk("cx_credit", credit, 15);
        change_ack = 1'b1;
        coin_valid = 1'b1; coin_type = 2'b00;
        tick();
        chk("cx_coin_rej", coin_reject, 1); chk("cx_credit_dec", credit, 14);
        for (int i = 0; i < 13; i++) tick();
        chk("cx_credit_1", credit, 1); chk("cx_still_req", change_req, 1);
        tick();
        change_ack = 1'b0;
        chk("cx_credit_0", credit, 0); chk("cx_req_drop", change_req, 0); chk("cx_busy_drop", busy, 0);

        // Vend item B at credit 5, auto change of 1
        coin(2'b10); chk("b_credit5", credit, 5);
        select(1'b1);
        chk("b_vend_req", vend_req, 1); chk("b_vend_item", vend_item, 1);
        chk("b_credit", credit, 1); chk("b_busy", busy, 1);
        vend_ack = 1'b1;
        tick();
        chk("b_vreq_drop", vend_req, 0); chk("b_change_req", change_req, 1); chk("b_credit_hold", credit, 1);
        change_ack = 1'b1;
        tick();
        change_ack = 1'b0;
        chk("b_credit0", credit, 0); chk("b_creq_drop", change_req, 0); chk("b_busy_drop", busy, 0);

        // Insufficient credit for item A
        coin(2'b01); chk("d_credit2", credit, 2);
        select(1'b0);
        chk("d_denied", sel_denied, 1); chk("d_credit", credit, 2); chk("d_vend_req", vend_req, 0);
        tick();      chk("d_denied_drop", sel_denied, 0);

        // Exact price: no change cycle follows
        coin(2'b00); chk("e_credit3", credit, 3);
        select(1'b0);
        chk("e_vend_req", vend_req, 1); chk("e_vend_item", vend_item, 0); chk("e_credit", credit, 0);
        vend_ack = 1'b1;
        tick();
        chk("e_vreq_drop", vend_req, 0); chk("e_no_change", change_req, 0); chk("e_busy", busy, 0);

        // Cancel + select + coin together at credit 6
        coin(2'b01);
        coin(2'b01);
        coin(2'b01); chk("f_credit6", credit, 6);
        cancel = 1'b1; sel_valid = 1'b1; sel = 1'b0; coin_valid = 1'b1; coin_type = 2'b00;
        tick();
        chk("f_coin_rej", coin_reject, 1); chk("f_change_req", change_req, 1);
        chk("f_vend_req", vend_req, 0); chk("f_sel_denied", sel_denied, 0); chk("f_credit", credit, 6);
        for (int i = 0; i < 12; i++) begin
            change_ack = (i % 2 == 0);
            tick();
            if (i == 5) begin
                chk("f_mid_credit", credit, 3);
                chk("f_mid_busy", busy, 1);
            end
        end
        change_ack = 1'b0;
        chk("f_credit0", credit, 0); chk("f_creq_drop", change_req, 0);

        // Reset during VEND at credit 4
        coin(2'b10);
        coin(2'b01); chk("g_credit7", credit, 7);
        select(1'b0);
        chk("g_vend_req", vend_req, 1); chk("g_credit4", credit, 4);
        resetn = 1'b0;
        tick();
        resetn = 1'b1;
        chk("g_rst_credit", credit, 0); chk("g_rst_vreq", vend_req, 0); chk("g_rst_busy", busy, 0);
        vend_ack = 1'b1;
        coin(2'b01);
        chk("g_coin_credit", credit, 2); chk("g_coin_rej", coin_reject, 0); chk("g_stray_ack", busy, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
